// File: rtl/parity_frame_rx_pkg.sv
// Shared definitions for the parity frame receiver: FSM states, frame width,
// line levels and the parity helper.
package parity_frame_rx_pkg;

    // Receiver FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_STOP  = 2'd2,
        ST_BREAK = 2'd3
    } rx_state_t;

    // Data nibble plus parity bit.
    localparam int FRAME_BITS = 5;

    // Level of an idle line and of a valid stop bit.
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic STOP_LEVEL = 1'b1;

    // Even parity over a full received word: 0 means the word is consistent.
    function automatic logic word_parity(input logic [FRAME_BITS-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/parity_frame_rx_sat_counter.sv
// Parameterised saturating up-counter with synchronous active-high reset.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, holding once every bit is set.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignment so every flop samples
        // pre-edge values regardless of block ordering.
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/parity_frame_rx.sv
// Framed one-wire receiver for 5-bit parity-tagged words. Checks framing and
// parity, holds one word on a valid/ready register, counts parity errors.
module parity_frame_rx
    import parity_frame_rx_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sin,
    input  logic                 sin_en,
    output logic [3:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 par_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 frame_err,
    output logic                 overrun
);

    rx_state_t             state, state_next;
    logic [2:0]            bit_idx, bit_idx_next;
    logic [FRAME_BITS-1:0] shreg, shreg_next;
    logic                  frame_ok;
    logic                  frame_bad;
    logic                  drain;
    logic                  load;
    logic                  drop;
    logic                  word_bad;

    // FSM state, bit index and shift register; all hold when sin_en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_next;
            bit_idx <= bit_idx_next;
            shreg   <= shreg_next;
        end
    end

    // Next-state logic: walk start, five word bits MSB first, then stop.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_next   = state;
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        frame_ok     = 1'b0;
        frame_bad    = 1'b0;
        if (sin_en) begin
            unique case (state)
                ST_IDLE: begin
                    if (sin != LINE_IDLE) begin
                        state_next   = ST_DATA;
                        bit_idx_next = 3'(FRAME_BITS - 1);
                    end
                end
                ST_DATA: begin
                    shreg_next = {shreg[FRAME_BITS-2:0], sin};
                    if (bit_idx == 3'd0) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx - 3'd1;
                    end
                end
                ST_STOP: begin
                    if (sin == STOP_LEVEL) begin
                        frame_ok   = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        // Line stuck low: wait for it to return high before
                        // looking for another start bit.
                        frame_bad  = 1'b1;
                        state_next = ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (sin == LINE_IDLE) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // A completed word loads if the buffer is empty or emptying this cycle.
    assign drain    = out_valid && out_ready;
    assign load     = frame_ok && (!out_valid || drain);
    assign drop     = frame_ok && !load;
    assign word_bad = word_parity(shreg);

    // Single-entry output register plus the registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_bad;
            overrun   <= drop;
            if (load) begin
                out_data  <= shreg[FRAME_BITS-1:1];
                par_err   <= word_bad;
                out_valid <= 1'b1;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Only words that actually reach the output register are counted.
    sat_counter #(
        .W(ERR_CNT_W)
    ) u_err_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (load && word_bad),
        .count(err_count)
    );

endmodule

// File: tb/tb_parity_frame_rx.sv
// Randomised self-checking bench for parity_frame_rx. Two instances share the
// stimulus: default counter width and a 2-bit counter for saturation.
module tb_parity_frame_rx;

    localparam int EV_NONE = 0;
    localparam int EV_GOOD = 1;
    localparam int EV_BAD  = 2;

    logic       clk = 1'b0;
    logic       rst, sin, sin_en, out_ready;
    logic [3:0] out_data, out_data_w2;
    logic       out_valid, out_valid_w2;
    logic       par_err, par_err_w2;
    logic [7:0] err_count;
    logic [1:0] err_count_w2;
    logic       frame_err, frame_err_w2;
    logic       overrun, overrun_w2;

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level reference state.
    logic       m_valid, m_par, m_ferr, m_ovr;
    logic [3:0] m_data;
    int         m_cnt8, m_cnt2;
    int         m_xfers, dut_xfers;

    always #5 clk = ~clk;

    parity_frame_rx dut (
        .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .par_err(par_err), .err_count(err_count),
        .frame_err(frame_err), .overrun(overrun)
    );

    parity_frame_rx #(.ERR_CNT_W(2)) dut_w2 (
        .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en),
        .out_data(out_data_w2), .out_valid(out_valid_w2), .out_ready(out_ready),
        .par_err(par_err_w2), .err_count(err_count_w2),
        .frame_err(frame_err_w2), .overrun(overrun_w2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic pick_ready(input int mode, input logic is_stop);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return 1'($urandom % 2);
            default: return is_stop;
        endcase
    endfunction

    // Drive one cycle, advance the reference on the edge, check at negedge.
    task automatic cycle(input logic s, input logic en, input logic rdy, input logic r,
                         input int ev, input logic [3:0] w, input logic p);
        logic drain;
        sin = s; sin_en = en; out_ready = rdy; rst = r;
        if (!r && out_valid && rdy) dut_xfers++;
        @(posedge clk);
        if (r) begin
            m_valid = 0; m_data = 0; m_par = 0; m_ferr = 0; m_ovr = 0;
            m_cnt8 = 0; m_cnt2 = 0;
        end else begin
            drain  = m_valid && rdy;
            if (drain) m_xfers++;
            m_ferr = (ev == EV_BAD);
            m_ovr  = 1'b0;
            if (ev == EV_GOOD && m_valid && !drain) begin
                m_ovr = 1'b1;
            end else if (ev == EV_GOOD) begin
                m_valid = 1'b1;
                m_data  = w;
                m_par   = p;
                if (p) begin
                    if (m_cnt8 < 255) m_cnt8++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
            end else if (drain) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", 32'(out_data), 32'(m_data));
        check("par_err", 32'(par_err), 32'(m_par));
        check("err_count", 32'(err_count), 32'(m_cnt8));
        check("frame_err", 32'(frame_err), 32'(m_ferr));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("err_count_w2", 32'(err_count_w2), 32'(m_cnt2));
        check("out_valid_w2", 32'(out_valid_w2), 32'(m_valid));
    endtask

    // Send one frame with optional parity/stop corruption and random gaps.
    task automatic send_frame(input logic [3:0] nib, input logic bad_par, input logic bad_stop,
                              input int ready_mode, input int max_gap);
        logic [6:0] bits;
        logic       p;
        int         gap;
        int         ev;
        bits[0] = 1'b0;
        bits[1] = nib[3];
        bits[2] = nib[2];
        bits[3] = nib[1];
        bits[4] = nib[0];
        bits[5] = (^nib) ^ bad_par;
        bits[6] = !bad_stop;
        p = ^{nib, bits[5]};
        for (int i = 0; i < 7; i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int g = 0; g < gap; g++)
                cycle(1'($urandom % 2), 1'b0, pick_ready(ready_mode, 1'b0), 1'b0, EV_NONE, nib, p);
            ev = (i == 6) ? (bad_stop ? EV_BAD : EV_GOOD) : EV_NONE;
            cycle(bits[i], 1'b1, pick_ready(ready_mode, i == 6), 1'b0, ev, nib, p);
        end
        if (bad_stop) begin
            for (int k = 0; k < 3; k++)
                cycle(1'b0, 1'b1, pick_ready(ready_mode, 1'b0), 1'b0, EV_NONE, nib, p);
            cycle(1'b1, 1'b1, pick_ready(ready_mode, 1'b0), 1'b0, EV_NONE, nib, p);
        end
    endtask

    initial begin
        int base;
        m_valid = 0; m_data = 0; m_par = 0; m_ferr = 0; m_ovr = 0;
        m_cnt8 = 0; m_cnt2 = 0; m_xfers = 0; dut_xfers = 0;
        sin = 1'b1; sin_en = 1'b0; out_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, EV_NONE, 4'h0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, EV_NONE, 4'h0, 1'b0);

        // Good frame, then bad parity, with the consumer always ready.
        send_frame(4'b1110, 1'b0, 1'b0, 1, 0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, EV_NONE, 4'h0, 1'b0);
        send_frame(4'b1110, 1'b1, 1'b0, 1, 0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, EV_NONE, 4'h0, 1'b0);

        // Framing error with held-low line, then a good frame.
        send_frame(4'b1010, 1'b0, 1'b1, 1, 0);
        send_frame(4'b0001, 1'b0, 1'b0, 1, 0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, EV_NONE, 4'h0, 1'b0);

        // Back-pressure: second back-to-back word overruns; one transfer.
        base = dut_xfers;
        send_frame(4'b0011, 1'b0, 1'b0, 0, 0);
        send_frame(4'b0101, 1'b0, 1'b0, 0, 0);
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0, EV_NONE, 4'h0, 1'b0);
        check("overrun_xfers", 32'(dut_xfers - base), 32'd1);

        // Drain and load on the same edge: both words transfer.
        base = dut_xfers;
        send_frame(4'b0011, 1'b0, 1'b0, 0, 0);
        send_frame(4'b0101, 1'b0, 1'b0, 3, 0);
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0, EV_NONE, 4'h0, 1'b0);
        check("drain_load_xfers", 32'(dut_xfers - base), 32'd2);

        // Five bad-parity words: 2-bit counter saturates at 3.
        for (int k = 0; k < 5; k++) send_frame(4'($urandom), 1'b1, 1'b0, 1, 1);
        check("sat_w2", 32'(err_count_w2), 32'd3);

        // Reset mid-frame with a word pending, then a clean frame.
        send_frame(4'b0110, 1'b0, 1'b0, 0, 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, EV_NONE, 4'h0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, EV_NONE, 4'h0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, EV_NONE, 4'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, EV_NONE, 4'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, EV_NONE, 4'h0, 1'b0);
        send_frame(4'b1001, 1'b0, 1'b0, 1, 0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, EV_NONE, 4'h0, 1'b0);

        // Randomised traffic: gaps, idle strobes, random back-pressure.
        for (int n = 0; n < 300; n++) begin
            int idle_strobes;
            idle_strobes = int'($urandom_range(2, 0));
            for (int k = 0; k < idle_strobes; k++)
                cycle(1'b1, 1'b1, pick_ready(2, 1'b0), 1'b0, EV_NONE, 4'h0, 1'b0);
            send_frame(4'($urandom), ($urandom % 4) == 0, ($urandom % 8) == 0, 2, 2);
        end
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0, EV_NONE, 4'h0, 1'b0);
        check("total_xfers", 32'(dut_xfers), 32'(m_xfers));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
